// File: rtl/cache_pkg.sv
// Shared trace-command codes, report scaling and FSM state type for the
// instruction-cache statistics stage.
package cache_pkg;

  localparam logic [3:0] CMD_FETCH      = 4'd2;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_RESET      = 4'd8;
  localparam logic [3:0] CMD_PRINT      = 4'd9;

  // Hit ratio is reported in per-mille; 0..1000 needs 10 bits.
  localparam int unsigned PM_SCALE = 1000;
  localparam int unsigned PM_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_DIV,
    ST_DONE
  } stats_state_t;

endpackage

// File: rtl/stats_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first bit is produced on the start edge, so NUM_W edges complete a
// division; done pulses in the cycle after the last bit, with quot stable.
module stats_divider #(
  parameter int unsigned NUM_W = 42,
  parameter int unsigned DEN_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int unsigned CNT_BITS = $clog2(NUM_W + 1);

  logic [CNT_BITS-1:0] cnt;
  logic [DEN_W-1:0]    rem;
  logic [DEN_W-1:0]    den_r;

  logic [NUM_W-1:0]    q_src;
  logic [DEN_W-1:0]    rem_src;
  logic [DEN_W-1:0]    den_use;
  logic [DEN_W:0]      trial;
  logic [DEN_W:0]      diff;
  logic                fits;
  logic [DEN_W-1:0]    rem_nxt;
  logic [NUM_W-1:0]    quot_nxt;

  // One restoring step; on start the operands come straight from the inputs.
  always_comb begin
    q_src    = start ? num : quot;
    rem_src  = start ? '0  : rem;
    den_use  = start ? den : den_r;
    trial    = {rem_src, q_src[NUM_W-1]};
    diff     = trial - {1'b0, den_use};
    fits     = (trial >= {1'b0, den_use});
    rem_nxt  = fits ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    quot_nxt = {q_src[NUM_W-2:0], fits};
  end

  // Iteration counter, partial remainder and quotient shift register.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      cnt   <= '0;
      rem   <= '0;
      den_r <= '0;
      quot  <= '0;
      done  <= 1'b0;
    end else if (start) begin
      cnt   <= CNT_BITS'(NUM_W - 1);
      rem   <= rem_nxt;
      den_r <= den;
      quot  <= quot_nxt;
      done  <= (NUM_W == 1);
    end else if (cnt != '0) begin
      cnt   <= cnt - 1'b1;
      rem   <= rem_nxt;
      quot  <= quot_nxt;
      done  <= (cnt == CNT_BITS'(1));
    end else begin
      done  <= 1'b0;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/ins_cache_stats.sv
// Instruction-cache statistics: saturating hit/miss counters plus an
// on-demand per-mille hit ratio computed without stalling the counters.
module ins_cache_stats
  import cache_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter logic [3:0]  FETCH_CMD = CMD_FETCH,
  parameter logic [3:0]  RESET_CMD = CMD_RESET,
  parameter logic [3:0]  PRINT_CMD = CMD_PRINT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic [3:0]      n,
  input  logic            hit,
  input  logic            miss,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] misses,
  output logic [CNT_W:0]   accesses,
  output logic [PM_W-1:0]  ratio_pm,
  output logic             ratio_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NUM_W = CNT_W + PM_W;
  localparam int unsigned DEN_W = CNT_W + 1;

  stats_state_t state, state_nxt;

  logic             is_fetch, is_clear, is_print;
  logic [CNT_W-1:0] hits_nxt, misses_nxt;
  logic [NUM_W-1:0] snap_num;
  logic             div_start, div_abort, div_busy, div_done;
  logic [NUM_W-1:0] div_quot;

  // Command decode and saturating counter next-values.
  always_comb begin
    is_fetch   = cmd_valid && (n == FETCH_CMD);
    is_clear   = cmd_valid && (n == RESET_CMD);
    is_print   = cmd_valid && (n == PRINT_CMD);
    hits_nxt   = hits;
    misses_nxt = misses;
    if (is_fetch && hit && !miss && (hits != '1))
      hits_nxt = hits + 1'b1;
    if (is_fetch && miss && !hit && (misses != '1))
      misses_nxt = misses + 1'b1;
    snap_num   = NUM_W'(hits) * NUM_W'(PM_SCALE);
  end

  // Report FSM next-state; a zero denominator skips the divide and aborts the
  // divider so its quotient reads back as zero in DONE.
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    div_abort = is_clear;
    unique case (state)
      ST_IDLE: if (is_print) state_nxt = ST_SNAP;
      ST_SNAP: begin
        if (accesses == '0) begin
          state_nxt = ST_DONE;
          div_abort = 1'b1;
        end else begin
          state_nxt = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done)
          state_nxt = ST_DONE;
        else if (!div_busy)
          state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (is_clear) begin
      state_nxt = ST_IDLE;
      div_start = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counters, error flag and ratio report registers.
  always_ff @(posedge clk) begin
    if (!rst_n || is_clear) begin
      hits        <= '0;
      misses      <= '0;
      accesses    <= '0;
      ratio_pm    <= '0;
      ratio_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      hits        <= hits_nxt;
      misses      <= misses_nxt;
      accesses    <= {1'b0, hits_nxt} + {1'b0, misses_nxt};
      ratio_valid <= (state == ST_DONE);
      if (is_fetch && hit && miss)
        err <= 1'b1;
      if (state == ST_DONE)
        ratio_pm <= PM_W'(div_quot);
    end
  end

  assign busy = (state != ST_IDLE);

  stats_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (snap_num),
    .den   (accesses),
    .abort (div_abort),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

endmodule

// File: tb/tb_ins_cache_stats.sv
// Directed bench for ins_cache_stats: scoreboard of expected ratio reports
// checked by a monitor, plus direct counter/flag checks.
module tb_ins_cache_stats;

  localparam int unsigned DIV32 = 42;
  localparam int unsigned DIV4  = 14;
  localparam logic [3:0] F_CMD = 4'd2;
  localparam logic [3:0] I_CMD = 4'd3;
  localparam logic [3:0] R_CMD = 4'd8;
  localparam logic [3:0] P_CMD = 4'd9;

  logic clk = 1'b0;
  logic rst_n, cmd_valid, hit, miss;
  logic [3:0] n;

  logic [31:0] hits, misses;
  logic [32:0] accesses;
  logic [9:0]  ratio_pm;
  logic        ratio_valid, busy, err;

  logic [3:0]  hits4, misses4;
  logic [4:0]  accesses4;
  logic [9:0]  ratio_pm4;
  logic        ratio_valid4, busy4, err4;

  typedef struct {
    int unsigned ratio;
    int unsigned due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned e4, k4;
  logic        got4;

  ins_cache_stats dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .n(n), .hit(hit), .miss(miss),
    .hits(hits), .misses(misses), .accesses(accesses), .ratio_pm(ratio_pm),
    .ratio_valid(ratio_valid), .busy(busy), .err(err)
  );

  ins_cache_stats #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .n(n), .hit(hit), .miss(miss),
    .hits(hits4), .misses(misses4), .accesses(accesses4), .ratio_pm(ratio_pm4),
    .ratio_valid(ratio_valid4), .busy(busy4), .err(err4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every ratio report must match the head of the scoreboard, value and cycle.
  always @(negedge clk) begin
    if (ratio_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_ratio_valid", ratio_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ratio_pm", ratio_pm, mon_e.ratio);
        chk("ratio_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic h, input logic m);
    @(negedge clk);
    cmd_valid = 1'b1; n = c; hit = h; miss = m;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; n = 4'd0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic print_exp(input int unsigned ratio, input int unsigned lat);
    exp_t e;
    send(P_CMD, 1'b0, 1'b0);
    e.ratio = ratio;
    e.due   = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int unsigned max);
    int unsigned k = 0;
    while (sb.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; n = 4'd0; hit = 1'b0; miss = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hits", hits, 0);
    chk("rst_misses", misses, 0);
    chk("rst_accesses", accesses, 0);
    chk("rst_ratio_pm", ratio_pm, 0);
    chk("rst_ratio_valid", ratio_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_hits4", hits4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 3 hits + 1 miss -> 750
    repeat (3) send(F_CMD, 1'b1, 1'b0);
    send(F_CMD, 1'b0, 1'b1);
    chk("t1_hits", hits, 3);
    chk("t1_misses", misses, 1);
    chk("t1_accesses", accesses, 4);
    print_exp(750, DIV32 + 2);
    chk("t1_busy", busy, 1);
    wait_drain(80);
    chk("t1_ratio_hold", ratio_pm, 750);
    chk("t1_idle", busy, 0);

    // 1 hit + 2 misses -> 333; PRINT while busy ignored, later fetch excluded
    send(R_CMD, 1'b0, 1'b0);
    chk("t2_clr_ratio", ratio_pm, 0);
    chk("t2_clr_hits", hits, 0);
    send(F_CMD, 1'b1, 1'b0);
    repeat (2) send(F_CMD, 1'b0, 1'b1);
    print_exp(333, DIV32 + 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_busy", busy, 1);
    end
    send(P_CMD, 1'b0, 1'b0);
    send(F_CMD, 1'b1, 1'b0);
    chk("t2_live_hits", hits, 2);
    chk("t2_live_accesses", accesses, 4);
    wait_drain(80);
    repeat (60) @(negedge clk);
    chk("t2_ratio_hold", ratio_pm, 333);
    chk("t2_busy_end", busy, 0);

    // zero accesses -> report 0 after 2 edges
    send(R_CMD, 1'b0, 1'b0);
    print_exp(0, 2);
    wait_drain(10);
    chk("t3_ratio", ratio_pm, 0);

    // hit&miss on fetch -> error, no count; non-fetch code ignored
    send(R_CMD, 1'b0, 1'b0);
    send(I_CMD, 1'b1, 1'b1);
    chk("t5_nonfetch_err", err, 0);
    chk("t5_nonfetch_hits", hits, 0);
    send(F_CMD, 1'b1, 1'b1);
    chk("t5_err", err, 1);
    chk("t5_hits", hits, 0);
    chk("t5_misses", misses, 0);
    send(F_CMD, 1'b0, 1'b1);
    chk("t5_err_sticky", err, 1);
    chk("t5_misses2", misses, 1);
    send(R_CMD, 1'b0, 1'b0);
    chk("t5_err_clr", err, 0);
    chk("t5_misses_clr", misses, 0);

    // completed report, then a report aborted by RESET_CMD 5 cycles in
    repeat (2) send(F_CMD, 1'b1, 1'b0);
    print_exp(1000, DIV32 + 2);
    wait_drain(80);
    chk("t6_ratio_pre", ratio_pm, 1000);
    send(F_CMD, 1'b0, 1'b1);
    send(P_CMD, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    send(R_CMD, 1'b0, 1'b0);
    chk("t6_busy", busy, 0);
    chk("t6_ratio", ratio_pm, 0);
    chk("t6_hits", hits, 0);
    chk("t6_misses", misses, 0);
    chk("t6_accesses", accesses, 0);
    repeat (60) @(negedge clk);
    chk("t6_ratio_after", ratio_pm, 0);

    // saturation on the 4-bit instance
    repeat (20) send(F_CMD, 1'b1, 1'b0);
    chk("t4_hits4", hits4, 15);
    chk("t4_accesses4", accesses4, 15);
    chk("t4_hits32", hits, 20);
    print_exp(1000, DIV32 + 2);
    e4 = cyc;
    got4 = 1'b0;
    k4 = 0;
    while (!got4 && k4 < 40) begin
      @(negedge clk);
      k4++;
      if (ratio_valid4 === 1'b1) begin
        got4 = 1'b1;
        chk("t4_ratio4", ratio_pm4, 1000);
        chk("t4_latency4", cyc, e4 + DIV4 + 2);
      end
    end
    chk("t4_ratio4_seen", got4, 1);
    wait_drain(80);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
